// File: rtl/tron_game_ctrl.sv
// Two-player Tron match sequencer: tick, heads, directions, crash detection, scores.
// Latency: all outputs registered; a deciding tick shows up one clk later.
// Backpressure: none; the renderer must accept a move_tick/round_reset pulse every cycle.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   start                   level; low outside idle aborts the match
//   p1_btn, p2_btn          {up,right,down,left} level buttons
//   p1_trail_hit/p2_...     renderer: next cell occupied (sampled at tick)
//   p1_x/p1_y/p2_x/p2_y     head centres; p1_dir/p2_dir 00 up 01 right 10 down 11 left
//   move_tick, round_reset  one-clk strobes to the renderer
//   p1_score, p2_score      round wins; state, last_result for LEDs/SSD
module tron_game_ctrl #(
  parameter int TICK_CYCLES = 524288,
  parameter int STEP        = 20,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 630,
  parameter int Y_MIN       = 10,
  parameter int Y_MAX       = 470,
  parameter int P1_X0       = 200,
  parameter int P1_Y0       = 200,
  parameter int P2_X0       = 440,
  parameter int P2_Y0       = 280,
  parameter int HOLD_TICKS  = 32,
  parameter int WIN_SCORE   = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] p1_btn,
  input  logic [3:0] p2_btn,
  input  logic       p1_trail_hit,
  input  logic       p2_trail_hit,
  output logic [9:0] p1_x,
  output logic [9:0] p1_y,
  output logic [9:0] p2_x,
  output logic [9:0] p2_y,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       move_tick,
  output logic       round_reset,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic [1:0] last_result
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CW-1:0] TC_LAST   = CW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [3:0]    WIN_W     = 4'(WIN_SCORE);

  // Bounds are evaluated in 11 bits so an underflowing 10-bit head cannot look legal.
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] X_LO    = 11'(X_MIN + STEP);
  localparam logic [10:0] Y_LO    = 11'(Y_MIN + STEP);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);

  localparam logic [9:0] P1_X0_W = 10'(P1_X0);
  localparam logic [9:0] P1_Y0_W = 10'(P1_Y0);
  localparam logic [9:0] P2_X0_W = 10'(P2_X0);
  localparam logic [9:0] P2_Y0_W = 10'(P2_Y0);
  localparam logic [1:0] DIR_UP   = 2'b00;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [9:0]    p1_x_q, p1_x_d, p1_y_q, p1_y_d;
  logic [9:0]    p2_x_q, p2_x_d, p2_y_q, p2_y_d;
  logic [1:0]    p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
  logic [1:0]    p1_pend_q, p1_pend_d, p2_pend_q, p2_pend_d;
  logic [3:0]    p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [1:0]    last_q, last_d;
  logic          move_tick_q, move_tick_d;
  logic          round_reset_q, round_reset_d;

  logic          running, tick, load_start, head_on;
  logic          p1_bv, p2_bv;
  logic [1:0]    p1_bd, p2_bd, p1_pend_eff, p2_pend_eff;
  logic          p1_oob, p2_oob, p1_crash, p2_crash;
  logic [10:0]   p1_nx, p1_ny, p2_nx, p2_ny;

  // One-hot button vector to direction code; bit 2 of the result flags a valid press.
  function automatic logic [2:0] decode_btn(input logic [3:0] b);
    case (b)
      4'b1000: return 3'b100;
      4'b0100: return 3'b101;
      4'b0010: return 3'b110;
      4'b0001: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Returns {out_of_bounds, next_x, next_y} for one step along d.
  function automatic logic [22:0] next_head(input logic [9:0] x, input logic [9:0] y,
                                            input logic [1:0] d);
    logic [10:0] xw, yw, nx, ny;
    logic        oob;
    xw  = {1'b0, x};
    yw  = {1'b0, y};
    nx  = xw;
    ny  = yw;
    oob = 1'b0;
    case (d)
      2'b00: begin ny = yw - STEP_W; oob = (yw < Y_LO);    end
      2'b01: begin nx = xw + STEP_W; oob = (nx > X_MAX_W); end
      2'b10: begin ny = yw + STEP_W; oob = (ny > Y_MAX_W); end
      default: begin nx = xw - STEP_W; oob = (xw < X_LO);  end
    endcase
    return {oob, nx, ny};
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    p1_x_d        = p1_x_q;
    p1_y_d        = p1_y_q;
    p2_x_d        = p2_x_q;
    p2_y_d        = p2_y_q;
    p1_dir_d      = p1_dir_q;
    p2_dir_d      = p2_dir_q;
    p1_pend_d     = p1_pend_q;
    p2_pend_d     = p2_pend_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    last_d        = last_q;
    move_tick_d   = 1'b0;
    round_reset_d = 1'b0;
    load_start    = 1'b0;

    running = (state_q == QGAME_1) || (state_q == QGAME_2);
    tick    = running && (cnt_q == TC_LAST);

    // A press this cycle competes with the pending value; reversal is judged
    // against the committed direction, not the pending one.
    {p1_bv, p1_bd} = decode_btn(p1_btn);
    {p2_bv, p2_bd} = decode_btn(p2_btn);
    p1_pend_eff = (p1_bv && (p1_bd != (p1_dir_q ^ 2'b10))) ? p1_bd : p1_pend_q;
    p2_pend_eff = (p2_bv && (p2_bd != (p2_dir_q ^ 2'b10))) ? p2_bd : p2_pend_q;

    {p1_oob, p1_nx, p1_ny} = next_head(p1_x_q, p1_y_q, p1_pend_eff);
    {p2_oob, p2_nx, p2_ny} = next_head(p2_x_q, p2_y_q, p2_pend_eff);

    head_on = ({p1_nx, p1_ny} == {p2_nx, p2_ny}) ||
              (({p1_nx, p1_ny} == {1'b0, p2_x_q, 1'b0, p2_y_q}) &&
               ({p2_nx, p2_ny} == {1'b0, p1_x_q, 1'b0, p1_y_q}));
    p1_crash = p1_oob | p1_trail_hit | head_on;
    p2_crash = p2_oob | p2_trail_hit | head_on;

    if (running) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      QI: begin
        if (start) begin
          state_d       = QGAME_1;
          load_start    = 1'b1;
          round_reset_d = 1'b1;
        end
      end
      QGAME_1: begin
        p1_pend_d = p1_pend_eff;
        p2_pend_d = p2_pend_eff;
        if (tick) begin
          p1_dir_d = p1_pend_eff;
          p2_dir_d = p2_pend_eff;
          if (!p1_crash && !p2_crash) begin
            p1_x_d      = p1_nx[9:0];
            p1_y_d      = p1_ny[9:0];
            p2_x_d      = p2_nx[9:0];
            p2_y_d      = p2_ny[9:0];
            move_tick_d = 1'b1;
          end else begin
            state_d = QGAME_2;
            if (p1_crash && p2_crash) begin
              last_d = 2'b11;
            end else if (p1_crash) begin
              last_d = 2'b10;
              if (p2_score_q != WIN_W) p2_score_d = p2_score_q + 4'd1;
            end else begin
              last_d = 2'b01;
              if (p1_score_q != WIN_W) p1_score_d = p1_score_q + 4'd1;
            end
          end
        end
      end
      QGAME_2: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            if ((p1_score_q == WIN_W) || (p2_score_q == WIN_W)) begin
              state_d = QDONE;
            end else begin
              state_d       = QGAME_1;
              load_start    = 1'b1;
              round_reset_d = 1'b1;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: ;
    endcase

    // Abort beats anything the tick decided above, including a move.
    if ((state_q != QI) && !start) begin
      state_d       = QI;
      p1_score_d    = 4'd0;
      p2_score_d    = 4'd0;
      last_d        = 2'b00;
      load_start    = 1'b1;
      round_reset_d = 1'b1;
      move_tick_d   = 1'b0;
    end

    if (load_start) begin
      p1_x_d    = P1_X0_W;
      p1_y_d    = P1_Y0_W;
      p2_x_d    = P2_X0_W;
      p2_y_d    = P2_Y0_W;
      p1_dir_d  = DIR_UP;
      p2_dir_d  = DIR_DOWN;
      p1_pend_d = DIR_UP;
      p2_pend_d = DIR_DOWN;
    end

    if (state_d != state_q) begin
      cnt_d  = '0;
      hold_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= QI;
      cnt_q         <= '0;
      hold_q        <= '0;
      p1_x_q        <= P1_X0_W;
      p1_y_q        <= P1_Y0_W;
      p2_x_q        <= P2_X0_W;
      p2_y_q        <= P2_Y0_W;
      p1_dir_q      <= DIR_UP;
      p2_dir_q      <= DIR_DOWN;
      p1_pend_q     <= DIR_UP;
      p2_pend_q     <= DIR_DOWN;
      p1_score_q    <= 4'd0;
      p2_score_q    <= 4'd0;
      last_q        <= 2'b00;
      move_tick_q   <= 1'b0;
      round_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      p1_x_q        <= p1_x_d;
      p1_y_q        <= p1_y_d;
      p2_x_q        <= p2_x_d;
      p2_y_q        <= p2_y_d;
      p1_dir_q      <= p1_dir_d;
      p2_dir_q      <= p2_dir_d;
      p1_pend_q     <= p1_pend_d;
      p2_pend_q     <= p2_pend_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      last_q        <= last_d;
      move_tick_q   <= move_tick_d;
      round_reset_q <= round_reset_d;
    end
  end

  assign p1_x        = p1_x_q;
  assign p1_y        = p1_y_q;
  assign p2_x        = p2_x_q;
  assign p2_y        = p2_y_q;
  assign p1_dir      = p1_dir_q;
  assign p2_dir      = p2_dir_q;
  assign move_tick   = move_tick_q;
  assign round_reset = round_reset_q;
  assign p1_score    = p1_score_q;
  assign p2_score    = p2_score_q;
  assign state       = state_q;
  assign last_result = last_q;

endmodule

// File: tb/tb_tron_game_ctrl.sv
module tb_tron_game_ctrl;

  localparam int TC   = 4;
  localparam int HT   = 4;
  localparam int STEP = 20;
  localparam int XMIN = 10;
  localparam int XMAX = 630;
  localparam int YMIN = 10;
  localparam int YMAX = 470;
  localparam int WIN  = 10;
  localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_DONE = 3;

  logic       clk, reset_n, start;
  logic [3:0] p1_btn, p2_btn;
  logic       p1_trail_hit, p2_trail_hit;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic [1:0] p1_dir, p2_dir, state, last_result;
  logic       move_tick, round_reset;
  logic [3:0] p1_score, p2_score;

  tron_game_ctrl #(.TICK_CYCLES(TC), .HOLD_TICKS(HT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .p1_btn(p1_btn), .p2_btn(p2_btn),
    .p1_trail_hit(p1_trail_hit), .p2_trail_hit(p2_trail_hit),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_dir(p1_dir), .p2_dir(p2_dir),
    .move_tick(move_tick), .round_reset(round_reset),
    .p1_score(p1_score), .p2_score(p2_score),
    .state(state), .last_result(last_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  // Reference model: match rules in plain integers.
  int m_st, m_cyc, m_ht, m_last, m_s1, m_s2, m_mt, m_rr;
  int m_x1, m_y1, m_x2, m_y2, m_d1, m_d2, m_pd1, m_pd2;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int stepx(input int d);
    return (d == 1) ? STEP : (d == 3) ? -STEP : 0;
  endfunction

  function automatic int stepy(input int d);
    return (d == 0) ? -STEP : (d == 2) ? STEP : 0;
  endfunction

  function automatic bit off_board(input int x, input int y);
    return (x < XMIN) || (x > XMAX) || (y < YMIN) || (y > YMAX);
  endfunction

  // Pending direction after this cycle's buttons: a single press that is not
  // the reverse of the committed heading replaces the pending value.
  function automatic int accept(input logic [3:0] b, input int committed, input int pend);
    int d;
    d = 0;
    if ($countones(b) != 1) return pend;
    for (int i = 0; i < 4; i++) if (b[3-i]) d = i;
    if (d == (committed + 2) % 4) return pend;
    return d;
  endfunction

  task automatic load_start_pos();
    m_x1 = 200; m_y1 = 200; m_x2 = 440; m_y2 = 280;
    m_d1 = 0; m_d2 = 2; m_pd1 = 0; m_pd2 = 2;
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_cyc = 0; m_ht = 0; m_last = 0; m_s1 = 0; m_s2 = 0;
    m_mt = 0; m_rr = 0;
    load_start_pos();
  endtask

  task automatic model_step();
    int ns, e1, e2, n1x, n1y, n2x, n2y;
    bit tk, c1, c2, load;
    m_mt = 0; m_rr = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    tk   = (m_st == S_RUN || m_st == S_HOLD) && (m_cyc % TC == TC - 1);
    ns   = m_st;
    load = 0;
    e1   = accept(p1_btn, m_d1, m_pd1);
    e2   = accept(p2_btn, m_d2, m_pd2);
    if (m_st != S_IDLE && !start) begin
      ns = S_IDLE; m_s1 = 0; m_s2 = 0; m_last = 0; load = 1; m_rr = 1;
    end else begin
      case (m_st)
        S_IDLE: if (start) begin ns = S_RUN; load = 1; m_rr = 1; end
        S_RUN: begin
          m_pd1 = e1; m_pd2 = e2;
          if (tk) begin
            m_d1 = e1; m_d2 = e2;
            n1x = m_x1 + stepx(e1); n1y = m_y1 + stepy(e1);
            n2x = m_x2 + stepx(e2); n2y = m_y2 + stepy(e2);
            c1 = off_board(n1x, n1y) || p1_trail_hit;
            c2 = off_board(n2x, n2y) || p2_trail_hit;
            if ((n1x == n2x && n1y == n2y) ||
                (n1x == m_x2 && n1y == m_y2 && n2x == m_x1 && n2y == m_y1)) begin
              c1 = 1; c2 = 1;
            end
            if (!c1 && !c2) begin
              m_x1 = n1x; m_y1 = n1y; m_x2 = n2x; m_y2 = n2y; m_mt = 1;
            end else begin
              ns = S_HOLD;
              if (c1 && c2) m_last = 3;
              else if (c1) begin m_last = 2; if (m_s2 < WIN) m_s2++; end
              else begin m_last = 1; if (m_s1 < WIN) m_s1++; end
            end
          end
        end
        S_HOLD: if (tk) begin
          m_ht++;
          if (m_ht == HT) begin
            if (m_s1 == WIN || m_s2 == WIN) ns = S_DONE;
            else begin ns = S_RUN; load = 1; m_rr = 1; end
          end
        end
        default: ;
      endcase
    end
    if (load) load_start_pos();
    if (ns != m_st) begin m_cyc = 0; m_ht = 0; end
    else m_cyc++;
    m_st = ns;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", int'(state), m_st);
      chk("last_result", int'(last_result), m_last);
      chk("p1_x", int'(p1_x), m_x1);
      chk("p1_y", int'(p1_y), m_y1);
      chk("p2_x", int'(p2_x), m_x2);
      chk("p2_y", int'(p2_y), m_y2);
      chk("p1_dir", int'(p1_dir), m_d1);
      chk("p2_dir", int'(p2_dir), m_d2);
      chk("p1_score", int'(p1_score), m_s1);
      chk("p2_score", int'(p2_score), m_s2);
      chk("move_tick", int'(move_tick), m_mt);
      chk("round_reset", int'(round_reset), m_rr);
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_round();
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycle();
      if (round_reset === 1'b1 && state === 2'b01) seen = 1;
    end
    chk("round_start_seen", int'(seen), 1);
  endtask

  // Assert trail hits exactly on the first tick of a freshly started round.
  task automatic hit_round(input logic h1, input logic h2);
    repeat (3) cycle();
    p1_trail_hit = h1;
    p2_trail_hit = h2;
    cycle();
    p1_trail_hit = 1'b0;
    p2_trail_hit = 1'b0;
    chk("hit_state", int'(state), 2);
  endtask

  function automatic logic [3:0] rand_btn();
    int r;
    r = $urandom_range(0, 99);
    if (r < 15) return 4'b0001 << $urandom_range(0, 3);
    if (r < 20) return 4'($urandom_range(0, 15));
    return 4'b0000;
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0; p1_btn = 4'b0; p2_btn = 4'b0;
    p1_trail_hit = 1'b0; p2_trail_hit = 1'b0;
    model_reset();
    cycle();
    cmp_en = 1;
    repeat (2) cycle();
    chk("rst_state", int'(state), 0);
    chk("rst_p1_x", int'(p1_x), 200);
    chk("rst_p2_y", int'(p2_y), 280);
    chk("rst_p2_dir", int'(p2_dir), 2);
    chk("rst_last", int'(last_result), 0);

    // Straight run: P1 up, P2 down, both hit the walls on the same tick.
    reset_n = 1'b1; start = 1'b1;
    cycle();
    chk("start_state", int'(state), 1);
    chk("start_rr", int'(round_reset), 1);
    for (int k = 1; k <= 10; k++) begin
      repeat (3) cycle();
      chk("pre_tick_mt", int'(move_tick), 0);
      cycle();
      if (k <= 9) begin
        chk("tick_mt", int'(move_tick), 1);
        chk("p1_y_step", int'(p1_y), 200 - 20 * k);
        chk("p2_y_step", int'(p2_y), 280 + 20 * k);
      end else begin
        chk("wall_state", int'(state), 2);
        chk("wall_last", int'(last_result), 3);
        chk("wall_p1_y", int'(p1_y), 20);
        chk("wall_p2_y", int'(p2_y), 460);
        chk("wall_p2_score", int'(p2_score), 0);
      end
    end
    wait_round();
    chk("reround_p1_y", int'(p1_y), 200);

    // Direction filtering: reversal and multi-press ignored, single press latched.
    p1_btn = 4'b0010; cycle();
    p1_btn = 4'b1001; cycle();
    p1_btn = 4'b0100; cycle();
    p1_btn = 4'b0000; cycle();
    chk("dir_right", int'(p1_dir), 1);
    chk("dir_right_x", int'(p1_x), 220);
    p1_btn = 4'b0001; cycle();
    p1_btn = 4'b1100; cycle();
    p1_btn = 4'b0000; cycle(); cycle();
    chk("dir_hold", int'(p1_dir), 1);
    chk("dir_hold_x", int'(p1_x), 240);
    p1_btn = 4'b0010; cycle();
    p1_btn = 4'b1000; cycle();
    p1_btn = 4'b0000; cycle(); cycle();
    chk("dir_latest", int'(p1_dir), 0);
    chk("dir_latest_y", int'(p1_y), 180);

    // Abort on the tick cycle: no move, back to idle.
    repeat (3) cycle();
    start = 1'b0; cycle();
    chk("abort_state", int'(state), 0);
    chk("abort_p1_y", int'(p1_y), 200);
    chk("abort_mt", int'(move_tick), 0);
    chk("abort_rr", int'(round_reset), 1);
    start = 1'b1; cycle();

    // Steer both heads into (320,240) on the same tick.
    p1_btn = 4'b0100; p2_btn = 4'b0001;
    repeat (24) cycle();
    chk("steer_p1_x", int'(p1_x), 320);
    chk("steer_p2_x", int'(p2_x), 320);
    p1_btn = 4'b0010; p2_btn = 4'b1000;
    repeat (8) cycle();
    chk("headon_last", int'(last_result), 3);
    chk("headon_state", int'(state), 2);
    chk("headon_p1_y", int'(p1_y), 220);
    chk("headon_p2_y", int'(p2_y), 260);
    chk("headon_score", int'(p1_score) + int'(p2_score), 0);
    p1_btn = 4'b0; p2_btn = 4'b0;
    wait_round();
    chk("after_hold_p2_x", int'(p2_x), 440);
    chk("after_hold_p1_dir", int'(p1_dir), 0);

    // Trail hits.
    hit_round(1'b1, 1'b0);
    chk("trail_p2_score", int'(p2_score), 1);
    chk("trail_last", int'(last_result), 2);
    wait_round();
    hit_round(1'b1, 1'b1);
    chk("trail_draw", int'(last_result), 3);
    chk("trail_draw_score", int'(p2_score), 1);

    // P1 wins ten rounds, then the match freezes.
    for (int k = 1; k <= 10; k++) begin
      wait_round();
      hit_round(1'b0, 1'b1);
      chk("win_p1_score", int'(p1_score), k);
    end
    for (int i = 0; i < 100 && state !== 2'b11; i++) cycle();
    chk("done_state", int'(state), 3);
    repeat (30) cycle();
    chk("frozen_state", int'(state), 3);
    chk("frozen_score", int'(p1_score), 10);
    chk("frozen_last", int'(last_result), 1);
    start = 1'b0; cycle();
    chk("clear_score", int'(p1_score), 0);
    chk("clear_state", int'(state), 0);
    start = 1'b1; cycle();

    // Asynchronous reset in the middle of the crash hold.
    hit_round(1'b1, 1'b0);
    repeat (5) cycle();
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("async_state", int'(state), 0);
    chk("async_p2_score", int'(p2_score), 0);
    chk("async_last", int'(last_result), 0);
    cycle();
    reset_n = 1'b1;

    // Random play.
    for (int i = 0; i < 20000; i++) begin
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 9999) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end
      p1_btn = rand_btn();
      p2_btn = rand_btn();
      p1_trail_hit = ($urandom_range(0, 11) == 0);
      p2_trail_hit = ($urandom_range(0, 11) == 0);
      if (m_st == S_DONE) start = ($urandom_range(0, 49) != 0);
      else if (!start) start = 1'b1;
      else start = ($urandom_range(0, 2999) != 0);
      cycle();
    end

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
